// File: rtl/reqack_responder.sv
// Target-side responder for a multi-channel req/ack/done handshake.
// Every channel runs an identical, independent FSM: delayed ack, one-cycle done, then waits for req release.
module reqack_responder #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned ACK_DLY  = 2,
  parameter int unsigned DONE_DLY = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enb,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] intrpt,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_DLY - 1);
  localparam logic [CNT_W-1:0] DONE_LOAD = CNT_W'(DONE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             ack_r;
    logic             done_r;
    logic             err_r;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        ack_r  <= 1'b0;
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req[g] && enb) begin
              state <= ST_WAIT;
              cnt   <= ACK_LOAD;
            end
          end
          ST_WAIT: begin
            if (intrpt[g]) begin
              state <= ST_REL;
            end else if (!req[g]) begin
              state <= ST_IDLE;
            end else if (cnt == '0) begin
              state <= ST_ACK;
              ack_r <= 1'b1;
              cnt   <= DONE_LOAD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_ACK: begin
            // Abort beats a req-drop violation, which beats normal completion.
            if (intrpt[g]) begin
              state  <= ST_REL;
              ack_r  <= 1'b0;
              done_r <= 1'b0;
            end else if (!req[g]) begin
              state  <= ST_IDLE;
              ack_r  <= 1'b0;
              done_r <= 1'b0;
              err_r  <= 1'b1;
            end else if (done_r) begin
              state  <= ST_REL;
              ack_r  <= 1'b0;
              done_r <= 1'b0;
            end else if (cnt == '0) begin
              done_r <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            if (!req[g]) begin
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end

    assign ack[g]  = ack_r;
    assign done[g] = done_r;
    assign err[g]  = err_r;
  end

endmodule
